// File: rtl/cfg_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_serializer
//  Purpose  : Parameterised parallel-to-serial converter. A WIDTH-bit word is
//             loaded through a valid/busy handshake and a runtime-selected
//             number of its low bits is shifted out, LSB- or MSB-first, one
//             bit per SER_EN strobe (the baud tick).
//  Macro    : SER_PARITY_EN - when defined, an optional parity bit (even/odd,
//             covering only the frame bits) is appended after the data bits.
//             When undefined, PAR_EN/PAR_TYP are ignored and frames are
//             exactly LEN bits long.
//  Ports    :
//    CLK        in   1       system clock, posedge
//    RST        in   1       asynchronous active-low reset
//    P_DATA     in   WIDTH   parallel word; frame = low LEN bits
//    DATA_VALID in   1       load request, accepted only while BUSY=0
//    CFG_LEN    in   CNT_W   frame length; 0 or >WIDTH means WIDTH
//    MSB_FIRST  in   1       0: bit0 first, 1: bit LEN-1 first
//    SER_EN     in   1       shift strobe, ignored while idle
//    PAR_EN     in   1       append parity bit (parity build only)
//    PAR_TYP    in   1       0 even, 1 odd (parity build only)
//    SER_DATA   out  1       registered serial bit
//    SER_DONE   out  1       one-clock pulse with the last bit of a frame
//    BUSY       out  1       frame in progress, loads blocked
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_serializer #(
   parameter int   WIDTH      = 8,
   parameter logic IDLE_LEVEL = 1'b0,
   localparam int  CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             DATA_VALID,
   input  logic [CNT_W-1:0] CFG_LEN,
   input  logic             MSB_FIRST,
   input  logic             SER_EN,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic             SER_DATA,
   output logic             SER_DONE,
   output logic             BUSY
);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
   } state_t;
`endif

   localparam logic [CNT_W-1:0] C_FULL_LEN = CNT_W'(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q,  data_d;
   logic [CNT_W-1:0]   len_q,   len_d;
   logic               msb_q,   msb_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               ser_q,   ser_d;
   logic               done_q,  done_d;
   logic               busy_q,  busy_d;

   logic [CNT_W-1:0]   w_len_clamped;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [CNT_W-1:0]   w_bit_idx;
   logic [WIDTH-1:0]   w_shifted;
   logic               w_frame_bit;
   logic               w_last_bit;

   // Out-of-range lengths fall back to a full word, decided once at load.
   assign w_len_clamped = ((CFG_LEN == '0) || (CFG_LEN > C_FULL_LEN)) ? C_FULL_LEN : CFG_LEN;

   assign w_cnt_inc  = cnt_q + CNT_W'(1);
   assign w_last_bit = (w_cnt_inc == len_q);

   // cnt_q counts bits already emitted; MSB-first walks down from LEN-1.
   assign w_bit_idx   = msb_q ? (len_q - CNT_W'(1) - cnt_q) : cnt_q;
   assign w_shifted   = data_q >> w_bit_idx;
   assign w_frame_bit = w_shifted[0];

`ifdef SER_PARITY_EN
   logic               par_en_q,  par_en_d;
   logic               par_typ_q, par_typ_d;
   logic [WIDTH-1:0]   w_len_mask;
   logic               w_parity;

   // Shifting by a full WIDTH yields zero, so the mask is all ones then.
   assign w_len_mask = ~({WIDTH{1'b1}} << len_q);
   assign w_parity   = (^(data_q & w_len_mask)) ^ par_typ_q;
`else
   logic               w_unused_par;
   assign w_unused_par = PAR_EN ^ PAR_TYP;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         len_q   <= '0;
         msb_q   <= 1'b0;
         cnt_q   <= '0;
         ser_q   <= IDLE_LEVEL;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         msb_q   <= msb_d;
         cnt_q   <= cnt_d;
         ser_q   <= ser_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

`ifdef SER_PARITY_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      len_d   = len_q;
      msb_d   = msb_q;
      cnt_d   = cnt_q;
      ser_d   = ser_q;
      done_d  = 1'b0;          // pulse: high only on the edge that ends a frame
      busy_d  = busy_q;
`ifdef SER_PARITY_EN
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // Load edge leaves SER_DATA alone; first bit follows on a later strobe.
            if (DATA_VALID) begin
               data_d  = P_DATA;
               len_d   = w_len_clamped;
               msb_d   = MSB_FIRST;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
`ifdef SER_PARITY_EN
               par_en_d  = PAR_EN;
               par_typ_d = PAR_TYP;
`endif
            end
         end

         ST_SHIFT: begin
            if (SER_EN) begin
               ser_d = w_frame_bit;
               cnt_d = w_cnt_inc;
               if (w_last_bit) begin
`ifdef SER_PARITY_EN
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                  end else begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = ST_IDLE;
                  end
`else
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
`endif
               end
            end
         end

`ifdef SER_PARITY_EN
         ST_PARITY: begin
            if (SER_EN) begin
               ser_d   = w_parity;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign SER_DATA = ser_q;
   assign SER_DONE = done_q;
   assign BUSY     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cfg_serializer
//  Purpose  : Self-checking bench for cfg_serializer (WIDTH=8). Directed frame
//             table plus hand-written sequences for async reset, slow strobe
//             with blocked loads, and back-to-back loads. Build with
//             SER_PARITY_EN defined to exercise the parity frames.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] p_data;
   logic       data_valid;
   logic [3:0] cfg_len;
   logic       msb_first;
   logic       ser_en;
   logic       par_en;
   logic       par_typ;
   logic       ser_data;
   logic       ser_done;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   cfg_serializer #(
      .WIDTH      (8),
      .IDLE_LEVEL (1'b0)
   ) u_dut (
      .CLK        (clk),
      .RST        (rst_n),
      .P_DATA     (p_data),
      .DATA_VALID (data_valid),
      .CFG_LEN    (cfg_len),
      .MSB_FIRST  (msb_first),
      .SER_EN     (ser_en),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .SER_DATA   (ser_data),
      .SER_DONE   (ser_done),
      .BUSY       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [3:0] len;
      logic       msb;
      logic       pe;
      logic       pt;
      int         n;        // expected number of emitted bits
      logic [0:8] seq;      // seq[0] is the first bit on the line
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_frame(input vec_t v, input int idx);
      logic prev;
      prev       = ser_data;
      p_data     = v.data;
      cfg_len    = v.len;
      msb_first  = v.msb;
      par_en     = v.pe;
      par_typ    = v.pt;
      ser_en     = 1'b1;
      data_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      check($sformatf("v%0d_load_busy", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d_load_hold", idx), 32'(ser_data), 32'(prev));
      check($sformatf("v%0d_load_done", idx), 32'(ser_done), 32'd0);
      for (int i = 0; i < v.n; i++) begin
         // shadowed inputs may wander during the frame
         p_data    = 8'($urandom);
         cfg_len   = 4'($urandom);
         msb_first = 1'($urandom);
         par_en    = 1'($urandom);
         par_typ   = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_bit%0d", idx, i), 32'(ser_data), 32'(v.seq[i]));
         check($sformatf("v%0d_done%0d", idx, i), 32'(ser_done), 32'(i == v.n - 1));
         check($sformatf("v%0d_busy%0d", idx, i), 32'(busy), 32'(i != v.n - 1));
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_post_done", idx), 32'(ser_done), 32'd0);
      check($sformatf("v%0d_post_busy", idx), 32'(busy), 32'd0);
      check($sformatf("v%0d_post_hold", idx), 32'(ser_data), 32'(v.seq[v.n-1]));
   endtask

   initial begin
      logic [7:0]  w_a5;
      logic [1:18] b2b_seq;
      int          par_n;

`ifdef SER_PARITY_EN
      par_n = 9;
`else
      par_n = 8;
`endif
      vecs[0] = '{8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 8,     9'b1010_0101_0};
      vecs[1] = '{8'h13, 4'd5,  1'b1, 1'b0, 1'b0, 5,     9'b1001_1000_0};
      vecs[2] = '{8'h13, 4'd0,  1'b1, 1'b0, 1'b0, 8,     9'b0001_0011_0};
      vecs[3] = '{8'h3C, 4'd12, 1'b0, 1'b0, 1'b0, 8,     9'b0011_1100_0};
      vecs[4] = '{8'h5A, 4'd3,  1'b0, 1'b0, 1'b0, 3,     9'b0100_0000_0};
      vecs[5] = '{8'h02, 4'd2,  1'b1, 1'b0, 1'b0, 2,     9'b1000_0000_0};
      vecs[6] = '{8'h07, 4'd8,  1'b0, 1'b1, 1'b0, par_n, 9'b1110_0000_1};
      vecs[7] = '{8'h07, 4'd8,  1'b0, 1'b1, 1'b1, par_n, 9'b1110_0000_0};
      vecs[8] = '{8'h07, 4'd8,  1'b0, 1'b0, 1'b1, 8,     9'b1110_0000_0};
      // parity over the 4 frame bits only (bit4 excluded): even -> 0
      vecs[9] = '{8'h1F, 4'd4,  1'b1, 1'b1, 1'b0, par_n - 4, 9'b1111_0000_0};

      rst_n = 1'b0; p_data = '0; data_valid = 1'b0; cfg_len = 4'd8;
      msb_first = 1'b0; ser_en = 1'b0; par_en = 1'b0; par_typ = 1'b0;

      // ---- reset state
      repeat (2) @(negedge clk);
      check("rst_ser",  32'(ser_data), 32'd0);
      check("rst_done", 32'(ser_done), 32'd0);
      check("rst_busy", 32'(busy),     32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- asynchronous reset three bits into a frame
      p_data = 8'hFF; cfg_len = 4'd8; msb_first = 1'b0; ser_en = 1'b1; data_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      data_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check("pre_rst_ser",  32'(ser_data), 32'd1);
      check("pre_rst_busy", 32'(busy),     32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ser",  32'(ser_data), 32'd0);
      check("mid_rst_done", 32'(ser_done), 32'd0);
      check("mid_rst_busy", 32'(busy),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // ---- directed frame table (vector 0 also shows a clean restart at bit0)
      for (int v = 0; v < 10; v++) run_frame(vecs[v], v);

      // ---- slow strobe (every 3rd cycle) with loads attempted while busy
      w_a5 = 8'hA5;
      p_data = 8'hA5; cfg_len = 4'd8; msb_first = 1'b0; par_en = 1'b0;
      ser_en = 1'b0; data_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      data_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         ser_en = ((k % 3) == 0);
         if (k == 4 || k == 10) begin
            data_valid = 1'b1;
            p_data     = 8'hFF;
         end else begin
            data_valid = 1'b0;
         end
         @(posedge clk); @(negedge clk);
         if (k >= 3) check($sformatf("slow_bit_k%0d", k), 32'(ser_data), 32'(w_a5[(k/3)-1]));
         check($sformatf("slow_done_k%0d", k), 32'(ser_done), 32'(k == 24));
         check($sformatf("slow_busy_k%0d", k), 32'(busy),     32'(k < 24));
      end
      ser_en = 1'b0; data_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("slow_done_pulse", 32'(ser_done), 32'd0);
      check("slow_idle_hold",  32'(ser_data), 32'd1);
      ser_en = 1'b1;
      @(posedge clk); @(negedge clk);
      check("idle_ignores_en", 32'(ser_data), 32'd1);
      check("idle_busy",       32'(busy),     32'd0);

      // ---- back-to-back: DATA_VALID held, second word loads in the done cycle
      // bits 1..8 of 0x0F, load edge (line holds), bits of 0xF0, then idle
      b2b_seq = 18'b1111_0000_0_0000_1111_1;
      p_data = 8'h0F; cfg_len = 4'd8; msb_first = 1'b0; ser_en = 1'b1; data_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      p_data = 8'hF0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); @(negedge clk);
         check($sformatf("b2b_bit_k%0d", k),  32'(ser_data), 32'(b2b_seq[k]));
         check($sformatf("b2b_done_k%0d", k), 32'(ser_done), 32'(k == 8 || k == 17));
         check($sformatf("b2b_busy_k%0d", k), 32'(busy),     32'(k < 8 || (k >= 9 && k <= 16)));
         if (k == 9) data_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
